// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one pmem port between the instruction-fetch unit (IFU, master 0)
//   and the load/store unit (LSU, master 1). One transaction is in flight at a
//   time: IDLE arbitrates and latches the request, REQ presents it to memory,
//   RESP waits for the memory response (with an optional timeout), and DONE
//   returns the response to the granted master.
//
//   Handshakes: every channel uses valid/ready. A transfer happens on the
//   rising edge where both valid and ready are 1. A valid, once raised by this
//   block, is held together with its data until ready is seen. Requesters need
//   only hold their request fields stable in the handshake cycle.
//
//   Timed-out transactions still owe a memory response. These late responses
//   are counted in stale_cnt and silently consumed before any new response is
//   accepted, so responses never get paired with the wrong request.
//
// Parameters:
//   PRIO_LSU  1 = LSU always wins ties, 0 = round-robin on ties
//   TIMEOUT   RESP cycles before an error response (0 = no timeout)
//   STALE_W   width of the stale-response counter (saturates at all-ones)
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   ifu_req_* / ifu_rsp_*        IFU request/response channels (read-only)
//   lsu_req_* / lsu_rsp_*        LSU request/response channels
//   mem_req_* / mem_rsp_*        memory request/response channels
//   dbg_state                    FSM state (0 IDLE, 1 REQ, 2 RESP, 3 DONE)
//   dbg_stale_cnt                outstanding stale responses
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter bit PRIO_LSU = 1'b0,
  parameter int TIMEOUT  = 16,
  parameter int STALE_W  = 3
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [31:0]        ifu_addr,
  output logic               ifu_rsp_valid,
  input  logic               ifu_rsp_ready,
  output logic [31:0]        ifu_rdata,
  output logic               ifu_rsp_err,

  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic [31:0]        lsu_addr,
  input  logic               lsu_wen,
  input  logic [31:0]        lsu_wdata,
  input  logic [3:0]         lsu_wmask,
  output logic               lsu_rsp_valid,
  input  logic               lsu_rsp_ready,
  output logic [31:0]        lsu_rdata,
  output logic               lsu_rsp_err,

  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [31:0]        mem_addr,
  output logic               mem_wen,
  output logic [31:0]        mem_wdata,
  output logic [3:0]         mem_wmask,
  input  logic               mem_rsp_valid,
  output logic               mem_rsp_ready,
  input  logic [31:0]        mem_rdata,

  output logic [1:0]         dbg_state,
  output logic [STALE_W-1:0] dbg_stale_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic G_IFU = 1'b0;
  localparam logic G_LSU = 1'b1;

  // The counter only has to reach TIMEOUT-1.
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [STALE_W-1:0] STALE_MAX = '1;

  state_e               state_q,      state_d;
  logic [STALE_W-1:0]   stale_q,      stale_d;
  logic [TO_W-1:0]      to_cnt_q,     to_cnt_d;
  logic                 grant_q,      grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [31:0]          addr_q,       addr_d;
  logic                 wen_q,        wen_d;
  logic [31:0]          wdata_q,      wdata_d;
  logic [3:0]           wmask_q,      wmask_d;
  logic [31:0]          rdata_q,      rdata_d;
  logic                 err_q,        err_d;

  logic ifu_win;
  logic lsu_win;
  logic stale_pending;
  logic grantee_rsp_ready;

  // Arbitration: a lone requester wins; on a tie, fixed priority gives the
  // LSU the grant, round-robin gives it to whoever was not granted last.
  always_comb begin
    ifu_win = 1'b0;
    lsu_win = 1'b0;
    if (ifu_req_valid && lsu_req_valid) begin
      if (PRIO_LSU)                  lsu_win = 1'b1;
      else if (last_grant_q == G_LSU) ifu_win = 1'b1;
      else                           lsu_win = 1'b1;
    end else begin
      ifu_win = ifu_req_valid;
      lsu_win = lsu_req_valid;
    end
  end

  assign stale_pending     = (stale_q != '0);
  assign grantee_rsp_ready = (grant_q == G_IFU) ? ifu_rsp_ready : lsu_rsp_ready;

  // req_ready is combinational, so it is explicitly forced low during reset.
  assign ifu_req_ready = rst && (state_q == S_IDLE) && ifu_win;
  assign lsu_req_ready = rst && (state_q == S_IDLE) && lsu_win;

  // In IDLE/DONE the port only opens to drain late responses; in RESP it is
  // always open (stale or real response).
  always_comb begin
    mem_rsp_ready = 1'b0;
    if (rst) begin
      case (state_q)
        S_RESP:         mem_rsp_ready = 1'b1;
        S_IDLE, S_DONE: mem_rsp_ready = stale_pending;
        default:        mem_rsp_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    stale_d      = stale_q;
    to_cnt_d     = to_cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    rdata_d      = rdata_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (mem_rsp_valid && stale_pending) stale_d = stale_q - STALE_W'(1);
        if (ifu_win) begin
          // Fetches are always full-word reads.
          addr_d       = ifu_addr;
          wen_d        = 1'b0;
          wdata_d      = 32'h0;
          wmask_d      = 4'hF;
          grant_d      = G_IFU;
          last_grant_d = G_IFU;
          state_d      = S_REQ;
        end else if (lsu_win) begin
          addr_d       = lsu_addr;
          wen_d        = lsu_wen;
          wdata_d      = lsu_wdata;
          wmask_d      = lsu_wmask;
          grant_d      = G_LSU;
          last_grant_d = G_LSU;
          state_d      = S_REQ;
        end
      end

      S_REQ: begin
        if (mem_req_ready) begin
          to_cnt_d = '0;
          state_d  = S_RESP;
        end
      end

      S_RESP: begin
        if (mem_rsp_valid && stale_pending) begin
          // Late response of an earlier timed-out transaction: drop it and
          // do not charge this cycle against the timeout.
          stale_d = stale_q - STALE_W'(1);
        end else if (mem_rsp_valid) begin
          rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          if (stale_q != STALE_MAX) stale_d = stale_q + STALE_W'(1);
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_DONE: begin
        if (mem_rsp_valid && stale_pending) stale_d = stale_q - STALE_W'(1);
        if (grantee_rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // last_grant resets to LSU so the first tie after reset goes to the IFU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      stale_q      <= '0;
      to_cnt_q     <= '0;
      grant_q      <= G_IFU;
      last_grant_q <= G_LSU;
      addr_q       <= 32'h0;
      wen_q        <= 1'b0;
      wdata_q      <= 32'h0;
      wmask_q      <= 4'h0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      stale_q      <= stale_d;
      to_cnt_q     <= to_cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Memory request fields come straight from the latched copy, so they stay
  // stable for as long as the memory stalls.
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  // The non-granted master sees an all-zero response channel.
  assign ifu_rsp_valid = (state_q == S_DONE) && (grant_q == G_IFU);
  assign lsu_rsp_valid = (state_q == S_DONE) && (grant_q == G_LSU);
  assign ifu_rdata     = ifu_rsp_valid ? rdata_q : 32'h0;
  assign lsu_rdata     = lsu_rsp_valid ? rdata_q : 32'h0;
  assign ifu_rsp_err   = ifu_rsp_valid && err_q;
  assign lsu_rsp_err   = lsu_rsp_valid && err_q;

  assign dbg_state     = state_q;
  assign dbg_stale_cnt = stale_q;

endmodule
